// File: rtl/bla_sub_pipe.sv
// Pipelined borrow-lookahead subtractor: one 4-bit group per stage, borrow
// carried between stages in registers, valid/ready on both sides.
module bla_sub_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTG = WIDTH / 4;
  localparam int LAST = NSTG - 1;

  // Returns {borrow_out, difference nibble}; all group borrows by lookahead.
  function automatic logic [4:0] bla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic bin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = ~a & b;
    p    = ~(a ^ b);
    c[0] = bin;
    c[1] = g[0] | (p[0] & bin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & bin);
    return {c[4], a ^ b ^ c[3:0]};
  endfunction

  logic [NSTG-1:0]  vld_q, bout_q, amsb_q, bmsb_q;
  logic [WIDTH-1:0] opa_q [NSTG];
  logic [WIDTH-1:0] opb_q [NSTG];
  logic [WIDTH-1:0] res_q [NSTG];
  logic             ovf_q, zero_q;

  logic [NSTG-1:0]  adv_d, inv_d, bin_d, am_d, bm_d, bout_d;
  logic [WIDTH-1:0] ina_d [NSTG];
  logic [WIDTH-1:0] inb_d [NSTG];
  logic [WIDTH-1:0] rin_d [NSTG];
  logic [WIDTH-1:0] res_d [NSTG];
  logic             ovf_d, zero_d;

  // Stall chain: a stage advances when its successor is empty or advancing.
  always_comb begin
    logic a;
    adv_d       = '0;
    a           = ~vld_q[LAST] | out_ready;
    adv_d[LAST] = a;
    for (int k = NSTG - 2; k >= 0; k--) begin
      a        = ~vld_q[k] | a;
      adv_d[k] = a;
    end
  end

  // Per-stage inputs, group computation and next-state results.
  always_comb begin
    logic [4:0] nib;
    inv_d[0] = in_valid;
    ina_d[0] = A;
    inb_d[0] = B;
    bin_d[0] = 1'b0;
    am_d[0]  = A[WIDTH-1];
    bm_d[0]  = B[WIDTH-1];
    rin_d[0] = '0;
    for (int k = 1; k < NSTG; k++) begin
      inv_d[k] = vld_q[k-1];
      ina_d[k] = opa_q[k-1];
      inb_d[k] = opb_q[k-1];
      bin_d[k] = bout_q[k-1];
      am_d[k]  = amsb_q[k-1];
      bm_d[k]  = bmsb_q[k-1];
      rin_d[k] = res_q[k-1];
    end
    for (int k = 0; k < NSTG; k++) begin
      nib            = bla4(ina_d[k][4*k +: 4], inb_d[k][4*k +: 4], bin_d[k]);
      res_d[k]       = rin_d[k];
      res_d[k][4*k +: 4] = nib[3:0];
      bout_d[k]      = nib[4];
    end
    ovf_d  = (am_d[LAST] ^ bm_d[LAST]) & (am_d[LAST] ^ res_d[LAST][WIDTH-1]);
    zero_d = ~|res_d[LAST];
  end

  // Stage registers; data only loads when a valid item moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      bout_q <= '0;
      amsb_q <= '0;
      bmsb_q <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSTG; k++) begin
        if (adv_d[k]) begin
          vld_q[k] <= inv_d[k];
          if (inv_d[k]) begin
            opa_q[k]  <= ina_d[k];
            opb_q[k]  <= inb_d[k];
            res_q[k]  <= res_d[k];
            bout_q[k] <= bout_d[k];
            amsb_q[k] <= am_d[k];
            bmsb_q[k] <= bm_d[k];
          end
        end
      end
      if (adv_d[LAST] && inv_d[LAST]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign in_ready  = adv_d[0];
  assign out_valid = vld_q[LAST];
  assign diff      = res_q[LAST];
  assign borrow    = bout_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
